// File: rtl/sap_controller.sv
// SAP-1 control sequencer: combinational control-word decode from the T-state ring
// and opcode, plus halt latch, invalid-T sticky error and completed-instruction count.
module sap_controller #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic [5:0]       t,
  input  logic [3:0]       op,
  output logic [11:0]      con,
  output logic             hlt,
  output logic             err,
  output logic [CNT_W-1:0] icount
);

  typedef enum logic [3:0] {
    OP_LDA = 4'b0000,
    OP_ADD = 4'b0001,
    OP_SUB = 4'b0010,
    OP_OUT = 4'b1110,
    OP_HLT = 4'b1111
  } op_e;

  typedef enum logic [5:0] {
    TS_T1 = 6'b100000,
    TS_T2 = 6'b010000,
    TS_T3 = 6'b001000,
    TS_T4 = 6'b000100,
    TS_T5 = 6'b000010,
    TS_T6 = 6'b000001
  } tstate_e;

  localparam int unsigned CP = 11, EP = 10, LM = 9, CE = 8, LI = 7, EI = 6;
  localparam int unsigned LA = 5,  EA = 4,  SU = 3, EU = 2, LB = 1, LO = 0;

  logic             r_hlt;
  logic             r_err;
  logic [CNT_W-1:0] r_icount;
  logic             w_t_valid;
  logic [11:0]      w_con;

  assign w_t_valid = (t != '0) && ((t & (t - 6'd1)) == '0);

  always_comb begin
    w_con = '0;
    if (w_t_valid && !r_hlt && !r_err) begin
      case (tstate_e'(t))
        TS_T1: begin w_con[EP] = 1'b1; w_con[LM] = 1'b1; end
        TS_T2: w_con[CP] = 1'b1;
        TS_T3: begin w_con[CE] = 1'b1; w_con[LI] = 1'b1; end
        TS_T4: begin
          case (op_e'(op))
            OP_LDA, OP_ADD, OP_SUB: begin w_con[LM] = 1'b1; w_con[EI] = 1'b1; end
            OP_OUT:                 begin w_con[EA] = 1'b1; w_con[LO] = 1'b1; end
            default:                w_con = '0;
          endcase
        end
        TS_T5: begin
          case (op_e'(op))
            OP_LDA:         begin w_con[CE] = 1'b1; w_con[LA] = 1'b1; end
            OP_ADD, OP_SUB: begin w_con[CE] = 1'b1; w_con[LB] = 1'b1; end
            default:        w_con = '0;
          endcase
        end
        TS_T6: begin
          case (op_e'(op))
            OP_ADD:  begin w_con[LA] = 1'b1; w_con[EU] = 1'b1; end
            OP_SUB:  begin w_con[LA] = 1'b1; w_con[EU] = 1'b1; w_con[SU] = 1'b1; end
            default: w_con = '0;
          endcase
        end
        default: w_con = '0;
      endcase
    end
  end

  // All three registers look only at pre-edge state; an invalid t can never equal
  // T6, so the error edge inherently suppresses the count.
  always_ff @(negedge clk or posedge res) begin
    if (res) begin
      r_hlt    <= 1'b0;
      r_err    <= 1'b0;
      r_icount <= '0;
    end else begin
      if (!w_t_valid)
        r_err <= 1'b1;
      if (t == TS_T4 && op == OP_HLT)
        r_hlt <= 1'b1;
      if (t == TS_T6 && !r_hlt && !r_err)
        r_icount <= r_icount + CNT_W'(1);
    end
  end

  assign con    = w_con;
  assign hlt    = r_hlt;
  assign err    = r_err;
  assign icount = r_icount;

endmodule

// File: tb/tb_sap_controller.sv
// Directed self-checking bench for sap_controller: fetch/execute decode, halt,
// invalid T-state, icount wrap and asynchronous reset.
module tb_sap_controller;

  localparam logic [5:0] T1 = 6'b100000, T2 = 6'b010000, T3 = 6'b001000;
  localparam logic [5:0] T4 = 6'b000100, T5 = 6'b000010, T6 = 6'b000001;

  logic        clk;
  logic        res;
  logic [5:0]  t;
  logic [3:0]  op;
  logic [11:0] con;
  logic        hlt;
  logic        err;
  logic [7:0]  icount;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  sap_controller #(.CNT_W(8)) dut (
    .clk    (clk),
    .res    (res),
    .t      (t),
    .op     (op),
    .con    (con),
    .hlt    (hlt),
    .err    (err),
    .icount (icount)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_regs(input string tag, input logic h, input logic e, input logic [7:0] ic);
    check({tag, " hlt"}, 32'(hlt), 32'(h));
    check({tag, " err"}, 32'(err), 32'(e));
    check({tag, " icount"}, 32'(icount), 32'(ic));
  endtask

  // Apply t/op just after posedge, check con mid-cycle, then move past the negedge.
  task automatic step(input string tag, input logic [5:0] tv, input logic [3:0] ov,
                      input logic [11:0] exp_con);
    @(posedge clk);
    #1 t = tv; op = ov;
    #1 check({tag, " con"}, 32'(con), 32'(exp_con));
    @(negedge clk);
    #1;
  endtask

  task automatic run_instr(input string tag, input logic [3:0] ov, input logic [11:0] c4,
                           input logic [11:0] c5, input logic [11:0] c6, input logic blank);
    step({tag, " T1"}, T1, ov, blank ? 12'h000 : 12'h600);
    step({tag, " T2"}, T2, ov, blank ? 12'h000 : 12'h800);
    step({tag, " T3"}, T3, ov, blank ? 12'h000 : 12'h180);
    step({tag, " T4"}, T4, ov, c4);
    step({tag, " T5"}, T5, ov, c5);
    step({tag, " T6"}, T6, ov, c6);
  endtask

  // Asserts res between edges and checks the clear before any negedge can occur.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #2 res = 1'b1;
    #1 check_regs({tag, " async"}, 1'b0, 1'b0, 8'd0);
    @(posedge clk);
    #1 t = T1;
    #1 res = 1'b0;
  endtask

  initial begin
    res = 1'b0; t = T1; op = 4'b0000;
    #1 res = 1'b1;
    #1 check_regs("reset", 1'b0, 1'b0, 8'd0);
    check("reset con", 32'(con), 32'h600);
    t = T6;
    @(negedge clk); #1;
    check("reset ignores negedge icount", 32'(icount), 32'd0);
    @(posedge clk);
    #1 t = T1;
    #1 res = 1'b0;

    run_instr("LDA", 4'b0000, 12'h240, 12'h120, 12'h000, 1'b0);
    check("LDA icount", 32'(icount), 32'd1);

    do_reset("pre-ALU");
    run_instr("ADD", 4'b0001, 12'h240, 12'h102, 12'h024, 1'b0);
    run_instr("SUB", 4'b0010, 12'h240, 12'h102, 12'h02C, 1'b0);
    check("ADD/SUB icount", 32'(icount), 32'd2);

    run_instr("OUT", 4'b1110, 12'h011, 12'h000, 12'h000, 1'b0);
    check_regs("after OUT", 1'b0, 1'b0, 8'd3);

    step("HLT T1", T1, 4'b1111, 12'h600);
    step("HLT T2", T2, 4'b1111, 12'h800);
    step("HLT T3", T3, 4'b1111, 12'h180);
    step("HLT T4", T4, 4'b1111, 12'h000);
    check("HLT hlt set", 32'(hlt), 32'd1);
    step("HLT T5", T5, 4'b1111, 12'h000);
    step("HLT T6", T6, 4'b1111, 12'h000);
    run_instr("halted LDA", 4'b0000, 12'h000, 12'h000, 12'h000, 1'b1);
    check_regs("halted", 1'b1, 1'b0, 8'd3);

    step("halted invalid", 6'b000110, 4'b0000, 12'h000);
    check_regs("halted err", 1'b1, 1'b1, 8'd3);

    step("pre-reset T5", T5, 4'b0001, 12'h000);
    do_reset("async T5");
    step("post-reset T1", T1, 4'b0000, 12'h600);
    step("post-reset T2", T2, 4'b0000, 12'h800);

    do_reset("pre-err");
    run_instr("LDA2", 4'b0000, 12'h240, 12'h120, 12'h000, 1'b0);
    step("invalid 000110", 6'b000110, 4'b0000, 12'h000);
    check_regs("invalid", 1'b0, 1'b1, 8'd1);
    run_instr("err ADD", 4'b0001, 12'h000, 12'h000, 12'h000, 1'b1);
    check("err frozen icount", 32'(icount), 32'd1);
    step("invalid 000000", 6'b000000, 4'b0000, 12'h000);
    check("err sticky", 32'(err), 32'd1);

    do_reset("pre-wrap");
    for (int i = 0; i < 255; i++)
      run_instr("NOP", 4'b0101, 12'h000, 12'h000, 12'h000, 1'b0);
    check("icount 255", 32'(icount), 32'd255);
    run_instr("NOP last", 4'b0101, 12'h000, 12'h000, 12'h000, 1'b0);
    check_regs("wrap", 1'b0, 1'b0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/sap_controller.md
SAP_CONTROLLER -- requirements
Module: sap_controller

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the completed-instruction counter.
REQ-002 SHALL have port clk, input, 1, system clock; all state updates on negedge clk.
REQ-003 SHALL have port res, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port t, input, 6, one-hot T-state from the ring counter: t[5]=T1, t[4]=T2, ..., t[0]=T6.
REQ-005 SHALL have port op, input, 4, instruction-register opcode nibble.
REQ-006 SHALL have port con, output, 12, active-high control word with bit map 11 Cp, 10 Ep, 9 Lm, 8 CE, 7 Li, 6 Ei, 5 La, 4 Ea, 3 Su, 2 Eu, 1 Lb, 0 Lo.
REQ-007 SHALL have port hlt, output, 1, halt latch; system clock gating uses ~hlt.
REQ-008 SHALL have port err, output, 1, sticky flag for a non-one-hot t.
REQ-009 SHALL have port icount, output, CNT_W, count of completed instructions.

Function
REQ-010 SHALL derive con combinationally from t, op, hlt and err; there are no registers in the con path.
REQ-011 SHALL decode the fetch states for every opcode: T1 drives Ep and Lm, T2 drives Cp, and T3 drives CE and Li.
REQ-012 SHALL decode LDA (0000): T4 drives Lm and Ei, T5 drives CE and La, and T6 drives no control bit.
REQ-013 SHALL decode ADD (0001): T4 drives Lm and Ei, T5 drives CE and Lb, and T6 drives La and Eu.
REQ-014 SHALL decode SUB (0010) identically to ADD, with Su additionally asserted at T6.
REQ-015 SHALL decode OUT (1110): T4 drives Ea and Lo, and T5 and T6 drive no control bit.
REQ-016 SHALL decode HLT (1111): T4, T5 and T6 drive no control bit.
REQ-017 SHALL treat every other opcode as a NOP: T4, T5 and T6 drive no control bit.
REQ-018 SHALL drive con = 0 whenever hlt=1 or err=1.
REQ-019 SHALL drive con = 0 whenever t is not one-hot, including t = 000000.
REQ-020 SHALL set hlt on the negedge clk at which t=000100 (T4) and op=1111.
REQ-021 SHALL hold hlt until res; no other event clears it.
REQ-022 SHALL keep con = 0 during the HLT T4 state; con remains 0 after hlt rises.
REQ-023 SHALL set err on any negedge clk at which t is not one-hot.
REQ-024 SHALL hold err until res; the err check operates even while hlt=1.
REQ-025 SHALL increment icount by 1 on each negedge clk with t=000001 (T6), hlt=0 and err=0.
REQ-026 SHALL wrap icount modulo 2^CNT_W.
REQ-027 SHALL NOT advance icount for a HLT instruction, because hlt is already set before its T6.
REQ-028 SHALL evaluate simultaneous events at one negedge from pre-edge state only.
REQ-029 SHALL set err and block the icount increment for that edge when t is invalid, even if the same edge would otherwise increment.

Reset
REQ-030 SHALL, while res=1, force hlt=0, err=0 and icount=0 immediately, independent of clk.
REQ-031 SHALL, while res=1, hold con as the combinational decode of t and op; with t=100000, con = 0x600 (Ep, Lm).
REQ-032 SHALL ignore negedge clk while res=1.
REQ-033 SHALL resume normal operation at the first negedge after res deasserts.
REQ-034 SHALL abandon any mid-instruction state on res; no partial state is retained.

Verification
REQ-035 SHALL cover the fetch sequence: res pulse, op=0000, t stepped T1..T6 -> con = 0x600, 0x800, 0x180, 0x240, 0x120, 0x000; icount=1 after the T6 negedge.
REQ-036 SHALL cover ADD and SUB: op=0001, then op=0010, each stepped T4..T6 -> con = 0x240, 0x102, 0x024 for ADD and 0x240, 0x102, 0x02C for SUB; icount=2.
REQ-037 SHALL cover OUT then HLT: op=1110 at T4 -> con=0x011; op=1111 at T4 negedge -> hlt=1, con=0 at T5 and T6, and icount unchanged across further cycles.
REQ-038 SHALL cover an invalid T-state: t=000110 at a negedge -> err=1, con=0 from then on, and icount frozen; then t=000000 -> err remains 1.
REQ-039 SHALL cover icount wrap: 256 NOP instructions (op=0101) with CNT_W=8 -> icount returns to 0, and con=0 at T4..T6 throughout.
REQ-040 SHALL cover asynchronous reset: res asserted between clock edges during T5 with hlt=1 and err=1 -> hlt=0, err=0 and icount=0 without a clock edge; the first post-reset T1 yields con=0x600.
